mmio_io_controller: RTL and testbench

Memory-mapped peripheral block between the processor data-memory port and board I/O. It replaces the fixed address decode in the top level with a parametrised one, and adds:
- per-channel input synchronisation and debouncing
- sticky rising-edge capture, cleared on read
- a LED output register
- a tone register with an optional self-expiring duration timer.

The processor read-data mux sits inside this block. RAM data passes through for all unmapped addresses.

---
 rtl/io_map_pkg.sv | 16 +
 rtl/mmio_io_controller_btn_debounce.sv | 50 +++++
 rtl/mmio_io_controller.sv | 132 +++++++++++++
 tb/tb_mmio_io_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Address map and timer state encoding shared by the MMIO I/O controller and its bench.
package io_map_pkg;

  localparam logic [31:0] ADDR_BTN      = 32'd1000;
  localparam logic [31:0] ADDR_EDGE     = 32'd1001;
  localparam logic [31:0] ADDR_RAND     = 32'd2000;
  localparam logic [31:0] ADDR_TONE     = 32'd3000;
  localparam logic [31:0] ADDR_TONE_DUR = 32'd3001;
  localparam logic [31:0] ADDR_LED      = 32'd3002;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/mmio_io_controller_btn_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level and a
// combinational pulse that is high on the edge where the level goes 0->1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised input disagrees with the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_d & ~level_q;

endmodule

// File: rtl/mmio_io_controller.sv
// Memory-mapped board I/O: debounced buttons with sticky edge flags, LED register,
// tone register with self-expiring duration timer, and the processor read-data mux.
module mmio_io_controller #(
  parameter int          N_BTN           = 4,
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter int          LED_WIDTH       = 15,
  parameter int          TONE_WIDTH      = 4,
  parameter int          RAND_WIDTH      = 4,
  parameter int          DUR_WIDTH       = 24,
  parameter logic [31:0] ADDR_BTN        = io_map_pkg::ADDR_BTN,
  parameter logic [31:0] ADDR_EDGE       = io_map_pkg::ADDR_EDGE,
  parameter logic [31:0] ADDR_RAND       = io_map_pkg::ADDR_RAND,
  parameter logic [31:0] ADDR_TONE       = io_map_pkg::ADDR_TONE,
  parameter logic [31:0] ADDR_TONE_DUR   = io_map_pkg::ADDR_TONE_DUR,
  parameter logic [31:0] ADDR_LED        = io_map_pkg::ADDR_LED
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_BTN-1:0]      btn_raw,
  input  logic [31:0]           mem_addr,
  input  logic                  mem_wren,
  input  logic                  mem_rden,
  input  logic [31:0]           mem_wdata,
  input  logic [31:0]           ram_rdata,
  input  logic [RAND_WIDTH-1:0] rand_in,
  output logic [31:0]           cpu_rdata,
  output logic [N_BTN-1:0]      btn_level,
  output logic [LED_WIDTH-1:0]  led_out,
  output logic [TONE_WIDTH-1:0] tone_out,
  output logic                  audio_en,
  output logic                  tone_busy
);

  import io_map_pkg::*;

  logic [N_BTN-1:0]      level, rise;
  logic [N_BTN-1:0]      edge_q, edge_d;
  logic [LED_WIDTH-1:0]  led_q;
  logic [TONE_WIDTH-1:0] tone_q;
  logic                  audio_q, busy_q;
  logic [DUR_WIDTH-1:0]  cnt_q;
  logic [DUR_WIDTH-1:0]  durVal;
  timer_state_e          state_q;
  logic                  readEdge, toneWr, durWr, ledWr;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock  (clock),
      .reset  (reset),
      .raw_i  (btn_raw[i]),
      .level_o(level[i]),
      .rise_o (rise[i])
    );
  end

  assign readEdge = mem_rden && (mem_addr == ADDR_EDGE);
  assign toneWr   = mem_wren && (mem_addr == ADDR_TONE);
  assign durWr    = mem_wren && (mem_addr == ADDR_TONE_DUR);
  assign ledWr    = mem_wren && (mem_addr == ADDR_LED);
  assign durVal   = mem_wdata[DUR_WIDTH-1:0];

  // A read only clears flags it returned; a rise on the same edge still sets its flag.
  always_comb begin
    edge_d = (readEdge ? '0 : edge_q) | rise;
  end

  always_comb begin
    if (mem_addr == ADDR_BTN) begin
      cpu_rdata = 32'(level);
    end else if (mem_addr == ADDR_EDGE) begin
      cpu_rdata = 32'(edge_q);
    end else if (mem_addr == ADDR_RAND) begin
      cpu_rdata = 32'(rand_in);
    end else begin
      cpu_rdata = ram_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      edge_q <= '0;
      led_q  <= '0;
    end else begin
      edge_q <= edge_d;
      if (ledWr) begin
        led_q <= mem_wdata[LED_WIDTH-1:0];
      end
    end
  end

  // Timer FSM; a tone store on the expiry edge keeps the new tone.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tone_q  <= '0;
      audio_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (toneWr) begin
        tone_q  <= mem_wdata[TONE_WIDTH-1:0];
        audio_q <= |mem_wdata;
      end
      if (durWr) begin
        cnt_q   <= durVal;
        busy_q  <= (durVal != '0);
        state_q <= (durVal != '0) ? RUN : IDLE;
      end else if (state_q == RUN) begin
        if (cnt_q == DUR_WIDTH'(1)) begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (!toneWr) begin
            tone_q  <= '0;
            audio_q <= 1'b0;
          end
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign btn_level = level;
  assign led_out   = led_q;
  assign tone_out  = tone_q;
  assign audio_en  = audio_q;
  assign tone_busy = busy_q;

endmodule

// File: tb/tb_mmio_io_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic, all outputs compared
// each cycle against a behavioural model of the I/O controller.
module tb_mmio_io_controller;

  localparam int N_BTN  = 4;
  localparam int DEB    = 4;
  localparam int LED_W  = 15;
  localparam int TONE_W = 4;
  localparam int RAND_W = 4;
  localparam int DUR_W  = 24;

  logic              clock = 1'b0;
  logic              reset;
  logic [N_BTN-1:0]  btnRaw;
  logic [31:0]       memAddr;
  logic              memWren;
  logic              memRden;
  logic [31:0]       memWdata;
  logic [31:0]       ramRdata;
  logic [RAND_W-1:0] randIn;
  logic [31:0]       cpuRdata;
  logic [N_BTN-1:0]  btnLevel;
  logic [LED_W-1:0]  ledOut;
  logic [TONE_W-1:0] toneOut;
  logic              audioEn;
  logic              toneBusy;

  int passCount  = 0;
  int totalCount = 0;

  // Model state: synchroniser view, run lengths of disagreement, and the visible registers.
  bit               modelValid = 0;
  logic [N_BTN-1:0] mS1, mS2, mLvl, mEdge;
  int               mRun[N_BTN];
  logic [LED_W-1:0] mLed;
  logic [TONE_W-1:0] mTone;
  logic             mAudio;
  int unsigned      mRemain;

  mmio_io_controller #(
    .N_BTN(N_BTN), .DEBOUNCE_CYCLES(DEB), .LED_WIDTH(LED_W),
    .TONE_WIDTH(TONE_W), .RAND_WIDTH(RAND_W), .DUR_WIDTH(DUR_W)
  ) dut (
    .clock(clock), .reset(reset), .btn_raw(btnRaw), .mem_addr(memAddr),
    .mem_wren(memWren), .mem_rden(memRden), .mem_wdata(memWdata),
    .ram_rdata(ramRdata), .rand_in(randIn), .cpu_rdata(cpuRdata),
    .btn_level(btnLevel), .led_out(ledOut), .tone_out(toneOut),
    .audio_en(audioEn), .tone_busy(toneBusy)
  );

  always #5 clock = ~clock;

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  function automatic logic [31:0] expectRdata();
    case (memAddr)
      32'd1000: return 32'(mLvl);
      32'd1001: return 32'(mEdge);
      32'd2000: return 32'(randIn);
      default:  return ramRdata;
    endcase
  endfunction

  task automatic checkOutput();
    if (!modelValid) return;
    compare("cpu_rdata", cpuRdata, expectRdata());
    compare("btn_level", 32'(btnLevel), 32'(mLvl));
    compare("led_out",   32'(ledOut),   32'(mLed));
    compare("tone_out",  32'(toneOut),  32'(mTone));
    compare("audio_en",  32'(audioEn),  32'(mAudio));
    compare("tone_busy", 32'(toneBusy), 32'(mRemain != 0));
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic modelStep();
    logic [N_BTN-1:0] newLvl;
    logic toneWr, durWr;
    if (reset) begin
      mS1 = '0; mS2 = '0; mLvl = '0; mEdge = '0;
      foreach (mRun[i]) mRun[i] = 0;
      mLed = '0; mTone = '0; mAudio = 1'b0; mRemain = 0;
      modelValid = 1;
      return;
    end
    newLvl = mLvl;
    for (int i = 0; i < N_BTN; i++) begin
      if (mS2[i] != mLvl[i]) begin
        mRun[i]++;
        if (mRun[i] == DEB) begin
          newLvl[i] = ~mLvl[i];
          mRun[i] = 0;
        end
      end else begin
        mRun[i] = 0;
      end
    end
    if (memRden && memAddr == 32'd1001) mEdge = '0;
    mEdge = mEdge | (newLvl & ~mLvl);
    mLvl = newLvl;
    mS2 = mS1;
    mS1 = btnRaw;
    if (memWren && memAddr == 32'd3002) mLed = memWdata[LED_W-1:0];
    toneWr = memWren && memAddr == 32'd3000;
    durWr  = memWren && memAddr == 32'd3001;
    if (toneWr) begin
      mTone  = memWdata[TONE_W-1:0];
      mAudio = (memWdata != 0);
    end
    if (durWr) begin
      mRemain = int'(memWdata[DUR_W-1:0]);
    end else if (mRemain != 0) begin
      mRemain--;
      if (mRemain == 0 && !toneWr) begin
        mTone  = '0;
        mAudio = 1'b0;
      end
    end
  endtask

  task automatic tick();
    #1;
    checkOutput();
    modelStep();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic wren, input logic rden,
                               input logic [31:0] wdata);
    memAddr  = addr;
    memWren  = wren;
    memRden  = rden;
    memWdata = wdata;
  endtask

  initial begin
    reset = 1'b1; btnRaw = '0; ramRdata = 32'hDEADBEEF; randIn = '0;
    applyStimulus(32'd0, 1'b0, 1'b0, 32'd0);
    tick(); tick();

    reset = 1'b0;
    applyStimulus(32'd1000, 1'b0, 1'b1, 32'd0);
    #1;
    compare("rst_rdata",  cpuRdata, 32'd0);
    compare("rst_level",  32'(btnLevel), 32'd0);
    compare("rst_led",    32'(ledOut), 32'd0);
    compare("rst_tone",   32'(toneOut), 32'd0);
    compare("rst_audio",  32'(audioEn), 32'd0);
    compare("rst_busy",   32'(toneBusy), 32'd0);
    tick();

    // Debounced rise on channel 2 appears exactly 6 edges after the raw change.
    applyStimulus(32'd0, 1'b0, 1'b0, 32'd0);
    btnRaw[2] = 1'b1;
    repeat (5) tick();
    #1 compare("deb_before", 32'(btnLevel), 32'd0);
    tick();
    #1 compare("deb_after", 32'(btnLevel), 32'h4);
    applyStimulus(32'd1001, 1'b0, 1'b1, 32'd0);
    #1 compare("edge_read1", cpuRdata, 32'h4);
    tick();
    #1 compare("edge_read2", cpuRdata, 32'h0);
    tick();
    applyStimulus(32'd0, 1'b0, 1'b0, 32'd0);
    btnRaw[1] = 1'b1;
    repeat (3) tick();
    btnRaw[1] = 1'b0;
    repeat (8) tick();
    #1 compare("glitch_level", 32'(btnLevel), 32'h4);

    // Channel 0 rises on the same edge as a clearing read of the edge flags.
    btnRaw[0] = 1'b1;
    repeat (5) tick();
    applyStimulus(32'd1001, 1'b0, 1'b1, 32'd0);
    #1 compare("coinc_pre", cpuRdata, 32'h0);
    tick();
    #1 compare("coinc_flag", cpuRdata, 32'h1);
    compare("coinc_level", 32'(btnLevel), 32'h5);
    tick();
    #1 compare("coinc_clr", cpuRdata, 32'h0);
    applyStimulus(32'd0, 1'b0, 1'b0, 32'd0);
    tick();

    applyStimulus(32'd3000, 1'b1, 1'b0, 32'h7); tick();
    applyStimulus(32'd0, 1'b0, 1'b0, 32'd0);
    #1 compare("tone7", 32'(toneOut), 32'h7);
    compare("aud7", 32'(audioEn), 32'h1);
    applyStimulus(32'd3000, 1'b1, 1'b0, 32'h10); tick();
    applyStimulus(32'd0, 1'b0, 1'b0, 32'd0);
    #1 compare("tone10", 32'(toneOut), 32'h0);
    compare("aud10", 32'(audioEn), 32'h1);
    applyStimulus(32'd3000, 1'b1, 1'b0, 32'h0); tick();
    applyStimulus(32'd0, 1'b0, 1'b0, 32'd0);
    #1 compare("aud0", 32'(audioEn), 32'h0);

    applyStimulus(32'd3000, 1'b1, 1'b0, 32'd5); tick();
    applyStimulus(32'd3001, 1'b1, 1'b0, 32'd3); tick();
    applyStimulus(32'd0, 1'b0, 1'b0, 32'd0);
    #1 compare("dur_tone", 32'(toneOut), 32'd5);
    for (int k = 0; k < 3; k++) begin
      #1 compare("dur3_busy", 32'(toneBusy), 32'd1);
      tick();
    end
    #1 compare("dur3_done", 32'(toneBusy), 32'd0);
    compare("dur3_tone", 32'(toneOut), 32'd0);
    compare("dur3_aud", 32'(audioEn), 32'd0);
    applyStimulus(32'd3000, 1'b1, 1'b0, 32'd5); tick();
    applyStimulus(32'd3001, 1'b1, 1'b0, 32'd3); tick();
    applyStimulus(32'd0, 1'b0, 1'b0, 32'd0); tick();
    applyStimulus(32'd3001, 1'b1, 1'b0, 32'd10); tick();
    applyStimulus(32'd0, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 10; k++) begin
      #1 compare("reload_busy", 32'(toneBusy), 32'd1);
      tick();
    end
    #1 compare("reload_done", 32'(toneBusy), 32'd0);
    compare("reload_tone", 32'(toneOut), 32'd0);

    applyStimulus(32'd3002, 1'b1, 1'b0, 32'h1ABCD); tick();
    applyStimulus(32'd0, 1'b0, 1'b0, 32'd0);
    #1 compare("led_trunc", 32'(ledOut), 32'h2BCD);
    randIn = 4'hA;
    applyStimulus(32'd2000, 1'b0, 1'b1, 32'd0);
    #1 compare("rand_read", cpuRdata, 32'h0000000A);
    applyStimulus(32'd500, 1'b0, 1'b1, 32'd0);
    #1 compare("ram_pass", cpuRdata, 32'hDEADBEEF);
    tick();

    // Randomized traffic, including occasional resets mid-operation.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] addr;
      logic [31:0] wdata;
      for (int i = 0; i < N_BTN; i++) begin
        if ($urandom_range(0, 15) == 0) btnRaw[i] = ~btnRaw[i];
      end
      reset    = ($urandom_range(0, 299) == 0);
      ramRdata = $urandom;
      randIn   = RAND_W'($urandom);
      case ($urandom_range(0, 7))
        0: addr = 32'd1000;
        1: addr = 32'd1001;
        2: addr = 32'd2000;
        3: addr = 32'd3000;
        4: addr = 32'd3001;
        5: addr = 32'd3002;
        6: addr = 32'd500;
        default: addr = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: wdata = 32'd0;
        1: wdata = $urandom_range(1, 15);
        2: wdata = 32'h10;
        default: wdata = $urandom;
      endcase
      if (addr == 32'd3001) wdata = $urandom_range(0, 12);
      applyStimulus(addr, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), wdata);
      tick();
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
